rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3; number of writeback requesters (2..8).
REQ-002 Parameter NUMREGS, default 1<<REG_ADDR_WIDTH; register count swept by clear.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester write request.
REQ-006 req_addr  input  NREQ*REG_ADDR_WIDTH  per-requester destination; requester i occupies slice i.
REQ-007 req_data  input  NREQ*DATA_WIDTH  per-requester write data; requester i occupies slice i.
REQ-008 req_ready  output  NREQ  one-hot-or-zero grant; a write transfers when valid&&ready.
REQ-009 clear_start  input  1  one-cycle pulse; zeroes every register.
REQ-010 clear_busy  output  1  high while the clear sweep runs.
REQ-011 wena  output  1  register-file write enable.
REQ-012 waddr  output  REG_ADDR_WIDTH  register-file write address.
REQ-013 wdata  output  DATA_WIDTH  register-file write data.

Function
REQ-014 The block shall arbitrate round-robin: the lowest index at or above ptr with req_valid wins, wrapping NREQ-1 to 0.
REQ-015 req_ready shall be combinational from req_valid, ptr and state; at most one bit set; never set for an invalid requester.
REQ-016 On a transfer by requester g, ptr shall become g+1 modulo NREQ; with no transfer, ptr shall hold.
REQ-017 wena/waddr/wdata shall be registered; a transfer in cycle N appears on the write port in cycle N+1 only.
REQ-018 With no transfer and no clear write, wena shall be 0 next cycle; waddr/wdata shall hold their previous values.
REQ-019 The write port never stalls; a lone valid requester shall be granted in the same cycle.
REQ-020 FSM states: IDLE (arbitrate) and CLEAR (sweep); exactly these two.
REQ-021 IDLE -> CLEAR on clear_start; that cycle's arbitration still completes normally.
REQ-022 In CLEAR, all req_ready shall be 0 and ptr shall hold.
REQ-023 In CLEAR, the block shall issue one write per cycle: address 0 up to NUMREGS-1 in order, data all zeros, wena=1.
REQ-024 CLEAR -> IDLE after issuing address NUMREGS-1; arbitration resumes in the following cycle.
REQ-025 clear_busy shall be 1 in exactly the NUMREGS cycles the FSM is in CLEAR.
REQ-026 clear_start during CLEAR shall be ignored and shall not restart the sweep.
REQ-027 Requester-held valid/addr/data under backpressure are the requester's duty; the block shall not buffer ungranted requests.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, ptr=0, wena=0, waddr=0, wdata=0, sweep counter=0.
REQ-029 req_ready shall be 0 during any cycle with rst=1.
REQ-030 Reset asserted mid-sweep shall abort CLEAR without completing remaining writes.

Configuration
REQ-031 Macro RF_WB_CLEAR_EN defined: the CLEAR state, sweep counter and clear behaviour shall be compiled in.
REQ-032 Macro RF_WB_CLEAR_EN undefined: clear_start shall be ignored, clear_busy tied 0, FSM permanently IDLE; the port list shall be unchanged.

Structure
REQ-033 REG_ADDR_WIDTH, DATA_WIDTH and the FSM state encoding shall come from the shared defines file.
REQ-034 The round-robin selector (valid vector + ptr -> one-hot grant, index) shall be a sub-module rr_select.
REQ-035 The block's write-port outputs shall connect directly to regfile wena/waddr/wdata without glue logic.

Verification
REQ-036 Reset, then req_valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; wena=1 from cycle 2 with matching addr/data.
REQ-037 Only req1 valid, addr=5, data=0xA5 -> req_ready=3'b010 same cycle; next cycle wena=1, waddr=5, wdata=0xA5.
REQ-038 ptr=2, req_valid=3'b011 -> requester 0 granted (wrap); ptr becomes 1.
REQ-039 With RF_WB_CLEAR_EN: clear_start pulse, requesters valid -> NUMREGS zero writes 0..NUMREGS-1; ready all 0; regfile reads 0 afterwards.
REQ-040 rst pulsed at sweep address 7 -> wena=0 next cycle, state IDLE, ptr=0; new clear_start restarts at address 0.
REQ-041 Without RF_WB_CLEAR_EN: clear_start pulse -> clear_busy stays 0; arbitration uninterrupted.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and FSM encoding for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 4;
    localparam int DATA_WIDTH     = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Round-robin pointer successor: g+1 wrapping at n
    function automatic int rr_succ(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_select.sv
// Round-robin selector: first valid requester at or above ptr wins, wrapping to 0.
// Latency: purely combinational.
// Backpressure: en=0 forces an all-zero grant.
module rr_select #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic            en,
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    // Scan NREQ candidates starting at ptr; the first valid one takes the grant
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (en && !any && valid[c]) begin
                grant[c] = 1'b1;
                idx      = PW'(c);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter onto a single register-file write port, with optional clear sweep (RF_WB_CLEAR_EN).
// Latency: granted write appears on wena/waddr/wdata one cycle after the transfer; clear issues one write per cycle.
// Backpressure: port never stalls; losing requesters hold their request, all ready low while clearing.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int NUMREGS = 1 << REG_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*REG_ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]                req_ready,
    input  logic                           clear_start,
    output logic                           clear_busy,
    output logic                           wena,
    output logic [REG_ADDR_WIDTH-1:0]      waddr,
    output logic [DATA_WIDTH-1:0]          wdata
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]             ptr;
    logic [PW-1:0]             gidx;
    logic                      xfer;
    logic                      arb_en;
    logic                      sweep;
    logic [REG_ADDR_WIDTH-1:0] cnt;

    rr_select #(.NREQ(NREQ), .PW(PW)) u_sel (
        .en    (arb_en),
        .valid (req_valid),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (gidx),
        .any   (xfer)
    );

`ifdef RF_WB_CLEAR_EN
    localparam logic [REG_ADDR_WIDTH-1:0] LAST = REG_ADDR_WIDTH'(NUMREGS - 1);

    state_t state, state_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: a second clear_start while sweeping is simply not looked at
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt == LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: arbitrate only in IDLE and never while reset is asserted
    always_comb begin
        arb_en = 1'b0;
        sweep  = 1'b0;
        if (state == ST_IDLE) arb_en = !rst;
        else                  sweep  = 1'b1;
    end

    // Sweep address counter, back to 0 once the last register is issued
    always_ff @(posedge clk) begin
        if (rst)        cnt <= '0;
        else if (sweep) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign arb_en             = !rst;
    assign sweep              = 1'b0;
    assign cnt                = '0;
`endif

    assign clear_busy = sweep;

    // Round-robin pointer moves past the winner only on an actual transfer
    always_ff @(posedge clk) begin
        if (rst)       ptr <= '0;
        else if (xfer) ptr <= PW'(rr_succ(int'(gidx), NREQ));
    end

    // Registered write port: sweep write, granted write, or idle with addr/data held
    always_ff @(posedge clk) begin
        if (rst) begin
            wena  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (sweep) begin
            wena  <= 1'b1;
            waddr <= cnt;
            wdata <= '0;
        end else if (xfer) begin
            wena  <= 1'b1;
            waddr <= req_addr[gidx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            wdata <= req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wena  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: round-robin order, wrap, write-port timing, clear sweep and reset abort.
// Latency: checks write port one cycle after each grant.
// Backpressure: requesters hold valid while not granted.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int NREQ    = 3;
    localparam int NUMREGS = 1 << REG_ADDR_WIDTH;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [NREQ-1:0]                req_valid;
    logic [NREQ*REG_ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0]     req_data;
    logic [NREQ-1:0]                req_ready;
    logic                           clear_start;
    logic                           clear_busy;
    logic                           wena;
    logic [REG_ADDR_WIDTH-1:0]      waddr;
    logic [DATA_WIDTH-1:0]          wdata;

    logic [DATA_WIDTH-1:0] rf [NUMREGS];

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .NUMREGS(NUMREGS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .wena        (wena),
        .waddr       (waddr),
        .wdata       (wdata)
    );

    always #5 clk = ~clk;

    // Register file fed straight from the write port
    always_ff @(posedge clk) begin
        if (wena) rf[waddr] <= wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input int a, input int d);
        check({tag, "_wena"},  32'(wena),  32'(en));
        check({tag, "_waddr"}, 32'(waddr), 32'(a));
        check({tag, "_wdata"}, 32'(wdata), 32'(d));
    endtask

    initial begin
        int nz;
        int guard;
        for (int i = 0; i < NUMREGS; i++) rf[i] = 8'hEE;
        rst         = 1'b1;
        req_valid   = 3'b111;
        req_addr    = {4'd3, 4'd2, 4'd1};
        req_data    = {8'h12, 8'h11, 8'h10};
        clear_start = 1'b0;

        // Reset state
        tick();
        tick();
        chk_wr("rst", 1'b0, 0, 0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);

        // All three valid: grants 0,1,2,0,1,2 with matching write one cycle later
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << (c % 3)));
            tick();
            chk_wr("rr_wr", 1'b1, (c % 3) + 1, 8'h10 + (c % 3));
        end

        // Idle cycle: wena drops, addr/data hold
        req_valid = 3'b000;
        #1;
        check("idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk_wr("idle_wr", 1'b0, 3, 8'h12);

        // Lone requester 1 granted in the same cycle
        req_valid = 3'b010;
        req_addr  = {4'd3, 4'd5, 4'd1};
        req_data  = {8'h12, 8'hA5, 8'h10};
        #1;
        check("lone_ready", 32'(req_ready), 32'b010);
        tick();
        chk_wr("lone_wr", 1'b1, 5, 8'hA5);

        // ptr=2 with only 0 and 1 valid: wrap to requester 0, ptr becomes 1
        req_addr  = {4'd3, 4'd2, 4'd1};
        req_data  = {8'h12, 8'h11, 8'h10};
        req_valid = 3'b011;
        #1;
        check("wrap_ready", 32'(req_ready), 32'b001);
        tick();
        chk_wr("wrap_wr", 1'b1, 1, 8'h10);
        req_valid = 3'b111;
        #1;
        check("wrap_ptr1", 32'(req_ready), 32'b010);
        tick();
        chk_wr("wrap_wr2", 1'b1, 2, 8'h11);

`ifdef RF_WB_CLEAR_EN
        // Clear with all requesters valid; the start cycle still grants requester 2
        clear_start = 1'b1;
        #1;
        check("clr_start_ready", 32'(req_ready), 32'b100);
        tick();
        clear_start = 1'b0;
        chk_wr("clr_last_arb", 1'b1, 3, 8'h12);
        for (int a = 0; a < NUMREGS; a++) begin
            clear_start = (a == 3);
            #1;
            check("clr_busy", 32'(clear_busy), 32'd1);
            check("clr_ready", 32'(req_ready), 32'd0);
            tick();
            chk_wr("clr_wr", 1'b1, a, 0);
        end
        clear_start = 1'b0;
        #1;
        check("clr_done_busy", 32'(clear_busy), 32'd0);
        check("clr_resume_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b000;
        nz = 0;
        for (int i = 0; i < NUMREGS; i++) if (rf[i] != 8'h00) nz++;
        check("clr_rf_zero", 32'(nz), 32'd0);

        // Reset while issuing sweep address 7 aborts the sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (7) tick();
        check("abort_pos", 32'(waddr), 32'd6);
        rst       = 1'b1;
        req_valid = 3'b111;
        #1;
        check("abort_rst_ready", 32'(req_ready), 32'd0);
        tick();
        chk_wr("abort_wr", 1'b0, 0, 0);
        check("abort_busy", 32'(clear_busy), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ptr0", 32'(req_ready), 32'b001);
        req_valid   = 3'b000;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("restart_busy", 32'(clear_busy), 32'd1);
        tick();
        chk_wr("restart_wr", 1'b1, 0, 0);
        guard = 0;
        while (clear_busy && guard < 40) begin
            tick();
            guard++;
        end
        check("restart_end_busy", 32'(clear_busy), 32'd0);
`else
        // Without the clear feature a clear_start pulse changes nothing
        clear_start = 1'b1;
        #1;
        check("noclr_ready", 32'(req_ready), 32'b100);
        tick();
        clear_start = 1'b0;
        chk_wr("noclr_wr", 1'b1, 3, 8'h12);
        #1;
        check("noclr_busy", 32'(clear_busy), 32'd0);
        check("noclr_ready2", 32'(req_ready), 32'b001);
        tick();
        chk_wr("noclr_wr2", 1'b1, 1, 8'h10);
        check("noclr_busy2", 32'(clear_busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
